// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational on fetch_pc; resolved-branch feedback trains
// the table on the clock edge and raises a one-cycle redirect on mispredicts.
module branch_predictor #(
    parameter int PC_SIZE = 16,
    parameter int ENTRIES = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [PC_SIZE-1:0] fetch_pc,
    output logic               predict_taken,
    output logic [PC_SIZE-1:0] predict_target,
    input  logic               fb_branch,
    input  logic [PC_SIZE-1:0] fb_pc,
    input  logic               fb_predict_taken,
    input  logic [PC_SIZE-1:0] fb_predict_target,
    input  logic               fb_feedback_taken,
    input  logic [PC_SIZE-1:0] fb_feedback_target,
    output logic               redirect_valid,
    output logic [PC_SIZE-1:0] redirect_pc,
    output logic [15:0]        branch_count,
    output logic [15:0]        mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_SIZE - IDX;

    logic [ENTRIES-1:0]              valid_q,  valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]   tag_q,    tag_d;
    logic [ENTRIES-1:0][1:0]         ctr_q,    ctr_d;
    logic [ENTRIES-1:0][PC_SIZE-1:0] target_q, target_d;

    logic               redirect_valid_q, redirect_valid_d;
    logic [PC_SIZE-1:0] redirect_pc_q,    redirect_pc_d;
    logic [15:0]        branch_count_q,   branch_count_d;
    logic [15:0]        mispredict_count_q, mispredict_count_d;

    logic [IDX-1:0]   fetch_idx, fb_idx;
    logic [TAG_W-1:0] fetch_tag, fb_tag;
    logic             fetch_hit, fb_hit, mispredict;

    // Zero-latency lookup; a miss or weak/strong not-taken falls through to pc+1.
    always_comb begin
        fetch_idx      = fetch_pc[IDX-1:0];
        fetch_tag      = fetch_pc[PC_SIZE-1:IDX];
        fetch_hit      = n_rst && valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        predict_taken  = fetch_hit && ctr_q[fetch_idx][1];
        predict_target = predict_taken ? target_q[fetch_idx] : fetch_pc + PC_SIZE'(1);
    end

    // Train the entry addressed by the resolved branch; not-taken misses never allocate.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        ctr_d    = ctr_q;
        target_d = target_q;
        fb_idx   = fb_pc[IDX-1:0];
        fb_tag   = fb_pc[PC_SIZE-1:IDX];
        fb_hit   = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
        if (fb_branch) begin
            if (fb_hit) begin
                if (fb_feedback_taken) begin
                    if (ctr_q[fb_idx] != 2'd3) begin
                        ctr_d[fb_idx] = ctr_q[fb_idx] + 2'd1;
                    end
                    target_d[fb_idx] = fb_feedback_target;
                end else if (ctr_q[fb_idx] != 2'd0) begin
                    ctr_d[fb_idx] = ctr_q[fb_idx] - 2'd1;
                end
            end else if (fb_feedback_taken) begin
                valid_d[fb_idx]  = 1'b1;
                tag_d[fb_idx]    = fb_tag;
                ctr_d[fb_idx]    = 2'd2;
                target_d[fb_idx] = fb_feedback_target;
            end
        end
    end

    // Mispredict detection drives the redirect pulse and the statistics counters.
    always_comb begin
        mispredict = fb_branch &&
                     ((fb_predict_taken != fb_feedback_taken) ||
                      (fb_feedback_taken && (fb_predict_target != fb_feedback_target)));
        redirect_valid_d   = mispredict;
        redirect_pc_d      = redirect_pc_q;
        if (mispredict) begin
            redirect_pc_d = fb_feedback_taken ? fb_feedback_target : fb_pc + PC_SIZE'(1);
        end
        branch_count_d     = branch_count_q + (fb_branch ? 16'd1 : 16'd0);
        mispredict_count_d = mispredict_count_q + (mispredict ? 16'd1 : 16'd0);
    end

    // State registers; reset empties the table and discards any pending redirect.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q            <= '0;
            tag_q              <= '0;
            ctr_q              <= '0;
            target_q           <= '0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            ctr_q              <= ctr_d;
            target_q           <= target_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios followed by randomized
// feedback traffic, all compared against a table model kept in this file.
module tb_branch_predictor;

    localparam int PC_SIZE = 16;
    localparam int ENTRIES = 16;

    logic        clk;
    logic        n_rst;
    logic [15:0] fetch_pc;
    logic        predict_taken;
    logic [15:0] predict_target;
    logic        fb_branch;
    logic [15:0] fb_pc;
    logic        fb_predict_taken;
    logic [15:0] fb_predict_target;
    logic        fb_feedback_taken;
    logic [15:0] fb_feedback_target;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int errors = 0;
    int checks = 0;

    // Reference model: per-slot record with integer counter, plus output registers.
    bit          mValid  [ENTRIES];
    int          mTag    [ENTRIES];
    int          mCtr    [ENTRIES];
    logic [15:0] mTarget [ENTRIES];
    logic        mRedirValid;
    logic [15:0] mRedirPc;
    logic [15:0] mBranchCnt;
    logic [15:0] mMissCnt;

    branch_predictor #(
        .PC_SIZE (PC_SIZE),
        .ENTRIES (ENTRIES)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .fetch_pc           (fetch_pc),
        .predict_taken      (predict_taken),
        .predict_target     (predict_target),
        .fb_branch          (fb_branch),
        .fb_pc              (fb_pc),
        .fb_predict_taken   (fb_predict_taken),
        .fb_predict_target  (fb_predict_target),
        .fb_feedback_taken  (fb_feedback_taken),
        .fb_feedback_target (fb_feedback_target),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Empty table and zeroed outputs, as seen right after reset.
    function automatic void clearModel();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = 0;
            mCtr[i]    = 0;
            mTarget[i] = 16'h0000;
        end
        mRedirValid = 1'b0;
        mRedirPc    = 16'h0000;
        mBranchCnt  = 16'h0000;
        mMissCnt    = 16'h0000;
    endfunction

    // Prediction from the model: slot = pc mod ENTRIES, tag = pc div ENTRIES.
    function automatic void modelPredict(input logic [15:0] pc, output logic tk,
                                         output logic [15:0] tg);
        int slot;
        int tagVal;
        slot   = int'(pc) % ENTRIES;
        tagVal = int'(pc) / ENTRIES;
        tk     = mValid[slot] && (mTag[slot] == tagVal) && (mCtr[slot] >= 2);
        tg     = tk ? mTarget[slot] : pc + 16'd1;
    endfunction

    // Apply one resolved branch to the model exactly as the rules describe.
    function automatic void modelUpdate(input logic b, input logic [15:0] p,
                                        input logic pt, input logic [15:0] ptgt,
                                        input logic ft, input logic [15:0] ftgt);
        int  slot;
        int  tagVal;
        bit  hit;
        bit  miss;
        slot   = int'(p) % ENTRIES;
        tagVal = int'(p) / ENTRIES;
        hit    = mValid[slot] && (mTag[slot] == tagVal);
        miss   = b && ((pt != ft) || (ft && (ptgt != ftgt)));
        if (b) begin
            if (hit) begin
                if (ft) begin
                    mCtr[slot]    = (mCtr[slot] < 3) ? mCtr[slot] + 1 : 3;
                    mTarget[slot] = ftgt;
                end else begin
                    mCtr[slot] = (mCtr[slot] > 0) ? mCtr[slot] - 1 : 0;
                end
            end else if (ft) begin
                mValid[slot]  = 1'b1;
                mTag[slot]    = tagVal;
                mCtr[slot]    = 2;
                mTarget[slot] = ftgt;
            end
            mBranchCnt = mBranchCnt + 16'd1;
        end
        mRedirValid = miss;
        if (miss) begin
            mRedirPc = ft ? ftgt : p + 16'd1;
        end
        if (miss) begin
            mMissCnt = mMissCnt + 16'd1;
        end
    endfunction

    // Single comparison point: counts, then reports and asserts on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
            $error("[TB] check %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // Registered outputs against the model.
    task automatic checkRegistered();
        checkOutput("redirect_valid", 32'(redirect_valid), 32'(mRedirValid));
        checkOutput("redirect_pc", 32'(redirect_pc), 32'(mRedirPc));
        checkOutput("branch_count", 32'(branch_count), 32'(mBranchCnt));
        checkOutput("mispredict_count", 32'(mispredict_count), 32'(mMissCnt));
    endtask

    // One cycle: drive at the falling edge, check the lookup before the rising
    // edge (pre-update contents), then check registered state after the edge.
    task automatic applyStimulus(input logic [15:0] f, input logic b, input logic [15:0] p,
                                 input logic pt, input logic [15:0] ptgt,
                                 input logic ft, input logic [15:0] ftgt);
        logic        expTk;
        logic [15:0] expTg;
        @(negedge clk);
        fetch_pc           = f;
        fb_branch          = b;
        fb_pc              = p;
        fb_predict_taken   = pt;
        fb_predict_target  = ptgt;
        fb_feedback_taken  = ft;
        fb_feedback_target = ftgt;
        #1;
        modelPredict(f, expTk, expTg);
        checkOutput("predict_taken", 32'(predict_taken), 32'(expTk));
        checkOutput("predict_target", 32'(predict_target), 32'(expTg));
        @(posedge clk);
        #1;
        modelUpdate(b, p, pt, ptgt, ft, ftgt);
        checkRegistered();
    endtask

    // Feedback for pc carrying whatever the model currently predicts for it.
    task automatic feedbackCorrect(input logic [15:0] p, input logic ft, input logic [15:0] ftgt);
        logic        tk;
        logic [15:0] tg;
        modelPredict(p, tk, tg);
        applyStimulus(p, 1'b1, p, tk, tg, ft, ftgt);
    endtask

    // Pulse reset low between clock edges and check the cleared state while low.
    task automatic pulseReset();
        n_rst     = 1'b0;
        fb_branch = 1'b0;
        #1;
        clearModel();
        checkOutput("reset_predict_taken", 32'(predict_taken), 32'd0);
        checkOutput("reset_predict_target", 32'(predict_target), 32'(fetch_pc + 16'd1));
        checkRegistered();
        #1;
        n_rst = 1'b1;
    endtask

    // Directed scenarios first, then randomized traffic over a small PC pool.
    initial begin
        logic [15:0] pool [6];
        logic [15:0] p;
        logic [15:0] f;
        logic [15:0] tgt;
        logic        ft;
        logic        expTk;
        logic [15:0] expTg;

        pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h0013;
        pool[3] = 16'h0113; pool[4] = 16'hFFFF; pool[5] = 16'h0005;

        n_rst = 1'b0; fetch_pc = 16'h0010; fb_branch = 1'b0; fb_pc = '0;
        fb_predict_taken = 1'b0; fb_predict_target = '0;
        fb_feedback_taken = 1'b0; fb_feedback_target = '0;
        clearModel();
        @(negedge clk);
        pulseReset();

        // Empty table after reset: fall-through prediction, counters zero.
        applyStimulus(16'h0010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("reset_fetch_0010_target", 32'(predict_target), 32'h0011);
        checkOutput("reset_counts_zero", 32'(branch_count), 32'd0);

        // Mispredicted taken branch with same-cycle lookup of that PC.
        applyStimulus(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0011, 1'b1, 16'h0040);
        checkOutput("first_redirect_pc", 32'(redirect_pc), 32'h0040);
        checkOutput("first_mispredict_count", 32'(mispredict_count), 32'd1);
        applyStimulus(16'h0010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("trained_predict_target", 32'(predict_target), 32'h0040);

        // Counter walk 2->3->3->2->1->0 with correct predictions supplied.
        feedbackCorrect(16'h0010, 1'b1, 16'h0040);
        feedbackCorrect(16'h0010, 1'b1, 16'h0040);
        feedbackCorrect(16'h0010, 1'b0, 16'h0000);
        feedbackCorrect(16'h0010, 1'b0, 16'h0000);
        applyStimulus(16'h0010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("flipped_not_taken", 32'(predict_taken), 32'd0);
        feedbackCorrect(16'h0010, 1'b0, 16'h0000);

        // Conflicting PC on the same slot replaces the resident entry.
        feedbackCorrect(16'h0010, 1'b1, 16'h0040);
        feedbackCorrect(16'h0010, 1'b1, 16'h0040);
        feedbackCorrect(16'h0020, 1'b1, 16'h0080);
        applyStimulus(16'h0010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("evicted_0010_target", 32'(predict_target), 32'h0011);
        applyStimulus(16'h0020, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("alloc_0020_target", 32'(predict_target), 32'h0080);

        // Not-taken miss must not allocate; back-to-back mispredicts.
        applyStimulus(16'h0033, 1'b1, 16'h0033, 1'b1, 16'h0050, 1'b0, 16'h0);
        applyStimulus(16'h0033, 1'b1, 16'h0044, 1'b0, 16'h0045, 1'b1, 16'h0123);
        checkOutput("b2b_redirect_pc", 32'(redirect_pc), 32'h0123);
        applyStimulus(16'h0044, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("redirect_pc_held", 32'(redirect_pc), 32'h0123);

        // Mispredict, then reset pulsed before the redirect is consumed.
        applyStimulus(16'h0044, 1'b1, 16'h0044, 1'b1, 16'h0999, 1'b1, 16'h0777);
        pulseReset();
        applyStimulus(16'h0044, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("post_reset_empty", 32'(predict_target), 32'h0045);

        // Randomized feedback: half the time the model's own prediction is supplied.
        for (int i = 0; i < 400; i++) begin
            p   = pool[$urandom_range(0, 5)];
            f   = pool[$urandom_range(0, 5)];
            ft  = 1'($urandom_range(0, 1));
            tgt = ($urandom_range(0, 1) == 0) ? 16'h0200 : 16'($urandom);
            modelPredict(p, expTk, expTg);
            if ($urandom_range(0, 1) == 0) begin
                applyStimulus(f, 1'b1, p, expTk, expTg, ft, tgt);
            end else begin
                applyStimulus(f, 1'($urandom_range(0, 3) != 0), p,
                              1'($urandom_range(0, 1)), 16'($urandom), ft, tgt);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_SIZE, default 16, program counter width in bits (word-addressed PC).
REQ-002 Parameter ENTRIES, default 16, table depth; power of two, >= 2; IDX = log2(ENTRIES).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 fetch_pc  input  PC_SIZE  PC being fetched this cycle.
REQ-006 predict_taken  output  1  combinational prediction for fetch_pc.
REQ-007 predict_target  output  PC_SIZE  combinational predicted next PC for fetch_pc.
REQ-008 fb_branch  input  1  feedback valid: a resolved branch is reported this cycle.
REQ-009 fb_pc  input  PC_SIZE  PC of the resolved branch.
REQ-010 fb_predict_taken  input  1  direction that was predicted for fb_pc.
REQ-011 fb_predict_target  input  PC_SIZE  target that was predicted for fb_pc.
REQ-012 fb_feedback_taken  input  1  resolved direction.
REQ-013 fb_feedback_target  input  PC_SIZE  resolved target; meaningful only when fb_feedback_taken=1.
REQ-014 redirect_valid  output  1  registered; fetch must restart at redirect_pc.
REQ-015 redirect_pc  output  PC_SIZE  registered corrected fetch PC.
REQ-016 branch_count  output  16  resolved branches seen, wraps.
REQ-017 mispredict_count  output  16  mispredictions seen, wraps.

Function
REQ-018 Table: ENTRIES direct-mapped entries, each {valid, tag[PC_SIZE-IDX], ctr[2], target[PC_SIZE]}; index = pc[IDX-1:0], tag = pc[PC_SIZE-1:IDX].
REQ-019 Hit: entry valid and tag match for fetch_pc.
REQ-020 Lookup is combinational, zero latency: hit && ctr[1]=1 -> predict_taken=1, predict_target=entry.target; otherwise predict_taken=0, predict_target=fetch_pc+1 (modulo 2^PC_SIZE).
REQ-021 Update occurs on the rising edge at which fb_branch=1; no table change when fb_branch=0.
REQ-022 Feedback hit: ctr saturating increment if taken (max 3), saturating decrement if not taken (min 0); target overwritten with fb_feedback_target only if taken.
REQ-023 Feedback miss, taken: allocate/replace entry: valid=1, tag from fb_pc, ctr=2 (weakly taken), target=fb_feedback_target.
REQ-024 Feedback miss, not taken: no allocation; existing entry at that index unchanged.
REQ-025 Mispredict = fb_branch && ((fb_predict_taken != fb_feedback_taken) || (fb_feedback_taken && fb_predict_target != fb_feedback_target)).
REQ-026 redirect_valid is high exactly one cycle after a mispredict cycle, low otherwise; redirect_pc = fb_feedback_taken ? fb_feedback_target : fb_pc+1, captured the same edge.
REQ-027 Back-to-back mispredicts produce back-to-back redirect pulses, each carrying its own redirect_pc.
REQ-028 redirect_pc holds its last value when redirect_valid=0.
REQ-029 Same-cycle lookup and update to the same index: lookup returns pre-update contents; new contents visible the following cycle.
REQ-030 branch_count increments by 1 per fb_branch cycle; mispredict_count increments by 1 per mispredict cycle; both wrap 0xFFFF -> 0x0000.

Reset
REQ-031 n_rst=0 asynchronously clears all valid bits, ctr=0, target=0, redirect_valid=0, redirect_pc=0, branch_count=0, mispredict_count=0.
REQ-032 Reset asserted mid-operation discards any pending redirect; first feedback after n_rst rises is treated as against an empty table.
REQ-033 While n_rst=0, predict_taken=0 and predict_target=fetch_pc+1.

Verification
REQ-034 After reset, fetch_pc=0x0010 -> predict_taken=0, predict_target=0x0011; counters 0.
REQ-035 Feedback fb_pc=0x0010, predicted not-taken, resolved taken to 0x0040 -> next cycle redirect_valid=1, redirect_pc=0x0040, mispredict_count=1; then fetch_pc=0x0010 predicts taken, 0x0040.
REQ-036 Same PC resolved taken twice more then not-taken three times (correct predictions supplied) -> ctr 3,3,2,1,0; prediction flips to not-taken after the second not-taken.
REQ-037 ENTRIES=16: allocate 0x0010 then taken feedback for 0x0020 (same index) -> 0x0010 now misses (not-taken, 0x0011), 0x0020 hits.
REQ-038 Feedback update and lookup of same PC in the same cycle -> lookup shows old value, next cycle new value.
REQ-039 Mispredict feedback, then n_rst pulsed low before the next edge -> redirect_valid stays 0, table empty, counters 0.
